// File: rtl/mmu_pkg.sv
// Shared definitions for the multi-channel address translator: segment
// encodings, the page-table entry layout and a segment classification helper.
package mmu_pkg;

    // Default address geometry; the entry layout below is built from these.
    localparam int MMU_AW        = 32;
    localparam int MMU_PAGE_BITS = 12;
    localparam int MMU_VPN_W     = MMU_AW - MMU_PAGE_BITS;

    // Unmapped segments, identified by va[31:29].
    localparam logic [2:0]  KSEG0     = 3'b100;
    localparam logic [2:0]  KSEG1     = 3'b101;
    // kseg0/kseg1 map to physical memory by dropping the segment bits.
    localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

    // One page-table entry: valid bit, virtual page number, physical frame number.
    typedef struct packed {
        logic                 v;
        logic [MMU_VPN_W-1:0] vpn;
        logic [MMU_VPN_W-1:0] pfn;
    } mmu_entry_t;

    // True for the fixed-mapping segments that never consult the table.
    function automatic logic is_unmapped_seg(input logic [2:0] seg);
        return (seg == KSEG0) || (seg == KSEG1);
    endfunction

endpackage

// File: rtl/mmu_lookup.sv
// Combinational translation for one channel: virtual address + page table +
// mapping enable -> physical address and miss fault.
module mmu_lookup
    import mmu_pkg::*;
#(
    parameter int NENT      = 8,
    parameter int AW        = MMU_AW,
    parameter int PAGE_BITS = MMU_PAGE_BITS
) (
    input  logic [AW-1:0] va,
    input  logic          map_en,
    input  mmu_entry_t    tlb_i [NENT],
    output logic [AW-1:0] pa,
    output logic          fault
);

    localparam int VPN_W = AW - PAGE_BITS;

    logic [NENT-1:0]  hit_vec;
    logic             hit_found;
    logic [VPN_W-1:0] hit_pfn;
    logic [2:0]       seg;

    assign seg = va[AW-1:AW-3];

    // Per-entry compare; all entries are searched in parallel.
    generate
        for (genvar gi = 0; gi < NENT; gi++) begin : g_cmp
            assign hit_vec[gi] = tlb_i[gi].v && (tlb_i[gi].vpn == va[AW-1:PAGE_BITS]);
        end
    endgenerate

    // Priority select: scanning from the top down lets the lowest matching index win.
    always_comb begin
        hit_found = 1'b0;
        hit_pfn   = '0;
        for (int i = NENT - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_found = 1'b1;
                hit_pfn   = tlb_i[i].pfn;
            end
        end
    end

    // Segment decode: fixed strip for kseg0/1, identity when unmapped, table otherwise.
    always_comb begin
        pa    = va;
        fault = 1'b0;
        if (is_unmapped_seg(seg)) begin
            pa = va & AW'(KSEG_MASK);
        end else if (map_en) begin
            if (hit_found) begin
                pa = {hit_pfn, va[PAGE_BITS-1:0]};
            end else begin
                pa    = '0;
                fault = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmu_xlate_mc.sv
// Multi-channel registered virtual->physical translator. One shared page table,
// one single-stage valid/ready pipeline per channel.
module mmu_xlate_mc
    import mmu_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int NENT      = 8,
    parameter int AW        = MMU_AW,
    parameter int PAGE_BITS = MMU_PAGE_BITS
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    map_en,
    input  logic [NCH-1:0]          req_valid,
    output logic [NCH-1:0]          req_ready,
    input  logic [NCH*AW-1:0]       req_va,
    output logic [NCH-1:0]          rsp_valid,
    input  logic [NCH-1:0]          rsp_ready,
    output logic [NCH*AW-1:0]       rsp_pa,
    output logic [NCH-1:0]          rsp_fault,
    input  logic                    cfg_we,
    input  logic [$clog2(NENT)-1:0] cfg_idx,
    input  logic [AW-PAGE_BITS-1:0] cfg_vpn,
    input  logic [AW-PAGE_BITS-1:0] cfg_pfn,
    input  logic                    cfg_v
);

    // Entry layout follows the package geometry (AW/PAGE_BITS defaults).
    mmu_entry_t tlb_reg [NENT];

    // Table write port; lookups in the same cycle read the pre-write contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NENT; i++) begin
                tlb_reg[i] <= '0;
            end
        end else if (cfg_we) begin
            tlb_reg[cfg_idx] <= '{v: cfg_v, vpn: cfg_vpn, pfn: cfg_pfn};
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [AW-1:0] va;
            logic [AW-1:0] lk_pa;
            logic          lk_fault;
            logic          accept;

            logic          rsp_valid_reg, rsp_valid_next;
            logic          rsp_fault_reg, rsp_fault_next;
            logic [AW-1:0] rsp_pa_reg,    rsp_pa_next;

            assign va = req_va[gi*AW +: AW];

            mmu_lookup #(
                .NENT      (NENT),
                .AW        (AW),
                .PAGE_BITS (PAGE_BITS)
            ) u_lookup (
                .va     (va),
                .map_en (map_en),
                .tlb_i  (tlb_reg),
                .pa     (lk_pa),
                .fault  (lk_fault)
            );

            // Stage is free when empty or being drained this cycle, so no bubble.
            assign req_ready[gi] = ~rsp_valid_reg | rsp_ready[gi];
            assign accept        = req_valid[gi] & req_ready[gi];

            // Next-state: load on accept, clear valid on drain, otherwise hold.
            always_comb begin
                rsp_valid_next = rsp_valid_reg;
                rsp_fault_next = rsp_fault_reg;
                rsp_pa_next    = rsp_pa_reg;
                if (accept) begin
                    rsp_valid_next = 1'b1;
                    rsp_fault_next = lk_fault;
                    rsp_pa_next    = lk_pa;
                end else if (rsp_ready[gi]) begin
                    rsp_valid_next = 1'b0;
                end
            end

            // Output stage register; reset drops any in-flight result.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    rsp_valid_reg <= 1'b0;
                    rsp_fault_reg <= 1'b0;
                    rsp_pa_reg    <= '0;
                end else begin
                    rsp_valid_reg <= rsp_valid_next;
                    rsp_fault_reg <= rsp_fault_next;
                    rsp_pa_reg    <= rsp_pa_next;
                end
            end

            assign rsp_valid[gi]         = rsp_valid_reg;
            assign rsp_fault[gi]         = rsp_fault_reg;
            assign rsp_pa[gi*AW +: AW]   = rsp_pa_reg;
        end
    endgenerate

endmodule

// File: tb/tb_mmu_xlate_mc.sv
// Self-checking bench for mmu_xlate_mc: directed scenario tasks with inline
// checks, plus a scoreboard that predicts every accepted request and matches
// it against the response when it is consumed.
module tb_mmu_xlate_mc;

    localparam int NCH  = 2;
    localparam int NENT = 8;
    localparam int AW   = 32;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              map_en = 1'b0;
    logic [NCH-1:0]    req_valid = '0;
    logic [NCH-1:0]    req_ready;
    logic [NCH*AW-1:0] req_va = '0;
    logic [NCH-1:0]    rsp_valid;
    logic [NCH-1:0]    rsp_ready = '0;
    logic [NCH*AW-1:0] rsp_pa;
    logic [NCH-1:0]    rsp_fault;
    logic              cfg_we = 1'b0;
    logic [2:0]        cfg_idx = '0;
    logic [19:0]       cfg_vpn = '0;
    logic [19:0]       cfg_pfn = '0;
    logic              cfg_v = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Reference page table and per-channel expected queues {fault, pa}.
    logic        m_v   [NENT];
    logic [19:0] m_vpn [NENT];
    logic [19:0] m_pfn [NENT];
    logic [32:0] q0 [$];
    logic [32:0] q1 [$];

    mmu_xlate_mc #(.NCH(NCH), .NENT(NENT), .AW(AW), .PAGE_BITS(12)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .map_en    (map_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_va    (req_va),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_pa    (rsp_pa),
        .rsp_fault (rsp_fault),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_vpn   (cfg_vpn),
        .cfg_pfn   (cfg_pfn),
        .cfg_v     (cfg_v)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] model_xlate(input logic [31:0] va, input logic me);
        logic [2:0] seg;
        seg = va[31:29];
        if (seg == 3'b100 || seg == 3'b101) return {1'b0, va & 32'h1FFF_FFFF};
        if (!me) return {1'b0, va};
        for (int i = 0; i < NENT; i++) begin
            if (m_v[i] && m_vpn[i] == va[31:12]) return {1'b0, m_pfn[i], va[11:0]};
        end
        return {1'b1, 32'h0};
    endfunction

    // Scoreboard: on the falling edge, inputs are stable; a consumed response is
    // popped and compared, an accepted request is predicted from the model table.
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                q0.delete();
                q1.delete();
                for (int i = 0; i < NENT; i++) m_v[i] = 1'b0;
            end else begin
                for (int ch = 0; ch < NCH; ch++) begin
                    logic [32:0] got;
                    logic [32:0] expv;
                    got = {rsp_fault[ch], rsp_pa[ch*AW +: AW]};
                    if (rsp_valid[ch] && rsp_ready[ch]) begin
                        n_vec++;
                        if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
                            n_err++;
                            $display("FAIL sb_ch%0d: unexpected response fault=%b pa=%h, required no response",
                                     ch, got[32], got[31:0]);
                        end else begin
                            if (ch == 0) expv = q0.pop_front();
                            else         expv = q1.pop_front();
                            if (got !== expv) begin
                                n_err++;
                                $display("FAIL sb_ch%0d: got fault=%b pa=%h, required fault=%b pa=%h",
                                         ch, got[32], got[31:0], expv[32], expv[31:0]);
                            end
                        end
                    end
                    if (req_valid[ch] && req_ready[ch]) begin
                        if (ch == 0) q0.push_back(model_xlate(req_va[31:0], map_en));
                        else         q1.push_back(model_xlate(req_va[63:32], map_en));
                    end
                end
                if (cfg_we) begin
                    m_v[cfg_idx]   = cfg_v;
                    m_vpn[cfg_idx] = cfg_vpn;
                    m_pfn[cfg_idx] = cfg_pfn;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic v,
                             input logic [19:0] vpn, input logic [19:0] pfn);
        cfg_we = 1'b1; cfg_idx = idx; cfg_v = v; cfg_vpn = vpn; cfg_pfn = pfn;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic drain(input string tag);
        req_valid = '0;
        rsp_ready = '1;
        for (int k = 0; k < 10 && (q0.size() != 0 || q1.size() != 0 || rsp_valid != 0); k++) tick();
        n_vec++;
        if (q0.size() != 0 || q1.size() != 0 || rsp_valid != 0) begin
            n_err++;
            $display("FAIL drain_%s: pending q0=%0d q1=%0d rsp_valid=%b, required all empty",
                     tag, q0.size(), q1.size(), rsp_valid);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick();
        n_vec++;
        if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_valid: got %b required 00", rsp_valid); end
        n_vec++;
        if (rsp_fault !== 2'b00) begin n_err++; $display("FAIL reset_fault: got %b required 00", rsp_fault); end
        n_vec++;
        if (rsp_pa !== 64'h0) begin n_err++; $display("FAIL reset_pa: got %h required 0", rsp_pa); end
        n_vec++;
        if (req_ready !== 2'b11) begin n_err++; $display("FAIL reset_ready: got %b required 11", req_ready); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_kseg();
        map_en = 1'b0;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        req_va = {32'h8000_1234, 32'hBFC0_0000};
        tick();
        n_vec++;
        if (rsp_valid !== 2'b11) begin n_err++; $display("FAIL kseg_valid: got %b required 11", rsp_valid); end
        n_vec++;
        if (rsp_pa[31:0] !== 32'h1FC0_0000 || rsp_fault[0] !== 1'b0) begin
            n_err++; $display("FAIL kseg1_ch0: got pa=%h fault=%b required pa=1fc00000 fault=0", rsp_pa[31:0], rsp_fault[0]);
        end
        n_vec++;
        if (rsp_pa[63:32] !== 32'h0000_1234 || rsp_fault[1] !== 1'b0) begin
            n_err++; $display("FAIL kseg0_ch1: got pa=%h fault=%b required pa=00001234 fault=0", rsp_pa[63:32], rsp_fault[1]);
        end
        // Unmapped mode: kuseg and kseg2 addresses pass through unchanged.
        req_va = {32'hC123_4567, 32'h0040_0ABC};
        tick();
        n_vec++;
        if (rsp_pa !== {32'hC123_4567, 32'h0040_0ABC} || rsp_fault !== 2'b00) begin
            n_err++; $display("FAIL passthru: got pa=%h fault=%b required pa=c123456700400abc fault=00", rsp_pa, rsp_fault);
        end
        drain("kseg");
    endtask

    task automatic test_mapped();
        cfg_write(3'd3, 1'b1, 20'h00400, 20'h12345);
        map_en = 1'b1;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        req_va = {32'h0050_0000, 32'h0040_0ABC};
        tick();
        n_vec++;
        if (rsp_pa[31:0] !== 32'h1234_5ABC || rsp_fault[0] !== 1'b0) begin
            n_err++; $display("FAIL map_hit: got pa=%h fault=%b required pa=12345abc fault=0", rsp_pa[31:0], rsp_fault[0]);
        end
        n_vec++;
        if (rsp_pa[63:32] !== 32'h0 || rsp_fault[1] !== 1'b1) begin
            n_err++; $display("FAIL map_miss: got pa=%h fault=%b required pa=00000000 fault=1", rsp_pa[63:32], rsp_fault[1]);
        end
        // kseg stays fixed with mapping on; kseg2 goes through the table and misses.
        req_va = {32'hC040_0000, 32'h9FC0_0004};
        tick();
        n_vec++;
        if (rsp_pa !== {32'h0, 32'h1FC0_0004} || rsp_fault !== 2'b10) begin
            n_err++; $display("FAIL map_seg: got pa=%h fault=%b required pa=000000001fc00004 fault=10", rsp_pa, rsp_fault);
        end
        drain("mapped");
    endtask

    task automatic test_backpressure();
        map_en = 1'b1;
        rsp_ready = 2'b10;
        req_valid = 2'b01;
        req_va[31:0] = 32'h0040_0001;
        tick();
        for (int k = 0; k < 3; k++) begin
            req_va[31:0] = 32'h0040_0010 + 32'(k);
            tick();
            n_vec++;
            if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b1 || rsp_pa[31:0] !== 32'h1234_5001) begin
                n_err++;
                $display("FAIL hold_%0d: got ready=%b valid=%b pa=%h required ready=0 valid=1 pa=12345001",
                         k, req_ready[0], rsp_valid[0], rsp_pa[31:0]);
            end
        end
        // Release: the waiting request (va ...012) is taken in the drain cycle, then one per cycle.
        rsp_ready = 2'b11;
        tick();
        n_vec++;
        if (rsp_valid[0] !== 1'b1 || rsp_pa[31:0] !== 32'h1234_5012) begin
            n_err++; $display("FAIL release: got valid=%b pa=%h required valid=1 pa=12345012", rsp_valid[0], rsp_pa[31:0]);
        end
        for (int k = 0; k < 4; k++) begin
            req_va[31:0] = 32'h0040_0020 + 32'(k);
            tick();
            n_vec++;
            if (rsp_valid[0] !== 1'b1 || rsp_pa[31:0] !== (32'h1234_5020 + 32'(k))) begin
                n_err++;
                $display("FAIL b2b_%0d: got valid=%b pa=%h required valid=1 pa=%h",
                         k, rsp_valid[0], rsp_pa[31:0], 32'h1234_5020 + 32'(k));
            end
        end
        drain("backpressure");
    endtask

    task automatic test_cfg_same_cycle();
        map_en = 1'b1;
        rsp_ready = 2'b11;
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_v = 1'b1; cfg_vpn = 20'h00777; cfg_pfn = 20'h54321;
        req_valid = 2'b01;
        req_va[31:0] = 32'h0077_7010;
        tick();
        cfg_we = 1'b0;
        n_vec++;
        if (rsp_fault[0] !== 1'b1 || rsp_pa[31:0] !== 32'h0) begin
            n_err++; $display("FAIL cfg_same: got fault=%b pa=%h required fault=1 pa=00000000", rsp_fault[0], rsp_pa[31:0]);
        end
        tick();
        n_vec++;
        if (rsp_fault[0] !== 1'b0 || rsp_pa[31:0] !== 32'h5432_1010) begin
            n_err++; $display("FAIL cfg_next: got fault=%b pa=%h required fault=0 pa=54321010", rsp_fault[0], rsp_pa[31:0]);
        end
        drain("cfg");
    endtask

    task automatic test_multi_hit();
        cfg_write(3'd5, 1'b1, 20'h00001, 20'hBBBBB);
        cfg_write(3'd1, 1'b1, 20'h00001, 20'hAAAAA);
        map_en = 1'b1;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        req_va = {32'h0000_1FFF, 32'h0000_1FFF};
        tick();
        n_vec++;
        if (rsp_pa !== {32'hAAAA_AFFF, 32'hAAAA_AFFF} || rsp_fault !== 2'b00) begin
            n_err++; $display("FAIL multi_hit: got pa=%h fault=%b required pa=aaaaafffaaaaafff fault=00", rsp_pa, rsp_fault);
        end
        drain("multi");
    endtask

    task automatic test_back_to_back();
        logic [19:0] vpns [4];
        vpns[0] = 20'h00400; vpns[1] = 20'h00001; vpns[2] = 20'h00777; vpns[3] = 20'h00ABC;
        for (int c = 0; c < 300; c++) begin
            map_en = 1'($urandom_range(0, 1));
            for (int ch = 0; ch < NCH; ch++) begin
                logic [31:0] va;
                int sel;
                sel = $urandom_range(0, 5);
                va = $urandom();
                case (sel)
                    0: va = {3'b100, va[28:0]};
                    1: va = {3'b101, va[28:0]};
                    2, 3, 4: va = {vpns[sel - 2], va[11:0]};
                    default: va = va;
                endcase
                req_va[ch*AW +: AW] = va;
                req_valid[ch] = ($urandom_range(0, 3) != 0);
                rsp_ready[ch] = ($urandom_range(0, 9) < 7);
            end
            cfg_we = ($urandom_range(0, 9) == 0);
            cfg_idx = 3'($urandom_range(0, 7));
            cfg_v = 1'($urandom_range(0, 1));
            cfg_vpn = vpns[$urandom_range(0, 3)];
            cfg_pfn = 20'($urandom());
            tick();
        end
        cfg_we = 1'b0;
        drain("random");
    endtask

    task automatic test_reset_mid();
        cfg_write(3'd3, 1'b1, 20'h00400, 20'h12345);
        map_en = 1'b1;
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        req_va = {32'h0040_0ABC, 32'h0040_0ABC};
        tick();
        req_valid = 2'b00;
        tick();
        n_vec++;
        if (rsp_valid !== 2'b11) begin n_err++; $display("FAIL mid_held: got valid=%b required 11", rsp_valid); end
        #2;
        resetn = 1'b0;
        #1;
        n_vec++;
        if (rsp_valid !== 2'b00 || rsp_pa !== 64'h0) begin
            n_err++; $display("FAIL mid_reset: got valid=%b pa=%h required valid=00 pa=0", rsp_valid, rsp_pa);
        end
        tick();
        resetn = 1'b1;
        tick();
        map_en = 1'b1;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        tick();
        n_vec++;
        if (rsp_valid !== 2'b11 || rsp_fault !== 2'b11 || rsp_pa !== 64'h0) begin
            n_err++; $display("FAIL mid_cleared: got valid=%b fault=%b pa=%h required valid=11 fault=11 pa=0",
                              rsp_valid, rsp_fault, rsp_pa);
        end
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_kseg();
        test_mapped();
        test_backpressure();
        test_cfg_same_cycle();
        test_multi_hit();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
